vga_fb_writer: RTL and testbench



---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_xy_counter.sv | 62 ++++++
 rtl/vga_fb_writer.sv | 209 ++++++++++++++++++++
 tb/tb_vga_fb_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer write engine.
//   - register offsets inside the 8-byte bus window
//   - CTRL / STATUS bit positions
//   - fill FSM state type
package vga_pkg;

  localparam logic [2:0] OFF_COL_FG = 3'd0;
  localparam logic [2:0] OFF_COL_BG = 3'd1;
  localparam logic [2:0] OFF_XREG   = 3'd2;
  localparam logic [2:0] OFF_YREG   = 3'd3;
  localparam logic [2:0] OFF_PIXEL  = 3'd4;
  localparam logic [2:0] OFF_CTRL   = 3'd5;
  localparam logic [2:0] OFF_STATUS = 3'd6;
  localparam logic [2:0] OFF_RSVD   = 3'd7;

  localparam int CTRL_AUTO_INC   = 0;
  localparam int CTRL_FILL_START = 1;
  localparam int CTRL_ERR_CLR    = 3;
  localparam int CTRL_FILL_LSB   = 4;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_ERR  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/vga_xy_counter.sv
// Raster X/Y counter with independent X/Y load, clear and increment.
// Increment steps X; at X_MAX it wraps X to 0 and steps Y; at
// (X_MAX, Y_MAX) both wrap to (0,0).
// Ports:
//   CLK, RESETN      clock, asynchronous active-low reset
//   i_clr            clear to (0,0) (highest priority)
//   i_inc            raster increment
//   i_load_x/i_x     load X (ignored while clearing/incrementing)
//   i_load_y/i_y     load Y (ignored while clearing/incrementing)
//   o_x, o_y         current position
//   o_wrap           position is (X_MAX, Y_MAX): next increment wraps
module vga_xy_counter #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 7,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              i_load_x,
  input  logic [X_BITS-1:0] i_x,
  input  logic              i_load_y,
  input  logic [Y_BITS-1:0] i_y,
  output logic [X_BITS-1:0] o_x,
  output logic [Y_BITS-1:0] o_y,
  output logic              o_wrap
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_MAX);

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_inc) begin
      // >= rather than == so a counter loaded past the edge still recovers
      if (r_x >= X_LAST) begin
        r_x <= '0;
        r_y <= (r_y >= Y_LAST) ? '0 : r_y + Y_BITS'(1);
      end else begin
        r_x <= r_x + X_BITS'(1);
      end
    end else begin
      if (i_load_x) r_x <= i_x;
      if (i_load_y) r_y <= i_y;
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_wrap = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/vga_fb_writer.sv
// Bus-mapped write engine for the VGA frame buffer A port.
// Decodes an 8-register window at BASE_ADDR on the 8-bit processor bus,
// performs single pixel writes (optionally auto-incrementing X/Y in raster
// order), runs a whole-screen fill, flags out-of-range / busy pixel writes
// in a sticky ERR bit and provides registered readback.
// Bus handshake: a write is one cycle with BUS_WE high and is always
// accepted (no back-pressure); reads have no strobe, BUS_RD_DATA shows the
// register addressed in the previous cycle.
// Ports:
//   CLK, RESETN     clock, asynchronous active-low reset
//   BUS_ADDR/DATA   bus address / write data, BUS_WE write strobe
//   BUS_RD_DATA     registered readback
//   CONFIG_COL      {foreground, background} colour
//   FB_ADDR/DATA/WE frame buffer write port, FB_ADDR = {Y,X}
//   BUSY            fill in progress
//   o_dbg_state     fill FSM state (debug)
module vga_fb_writer
  import vga_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int         X_BITS    = 8,
  parameter int         Y_BITS    = 7,
  parameter int         PIX_BITS  = 1,
  parameter int         X_MAX     = 159,
  parameter int         Y_MAX     = 119
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [7:0]               BUS_ADDR,
  input  logic [7:0]               BUS_DATA,
  input  logic                     BUS_WE,
  output logic [7:0]               BUS_RD_DATA,
  output logic [15:0]              CONFIG_COL,
  output logic [X_BITS+Y_BITS-1:0] FB_ADDR,
  output logic [PIX_BITS-1:0]      FB_DATA,
  output logic                     FB_WE,
  output logic                     BUSY,
  output logic                     o_dbg_state
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_MAX);
  // The CTRL fill field is 4 bits wide; only PIX_BITS of it are kept.
  localparam int FILL_W = (PIX_BITS < 4) ? PIX_BITS : 4;

  fill_state_e                r_state;
  logic [7:0]                 r_col_fg;
  logic [7:0]                 r_col_bg;
  logic                       r_auto_inc;
  logic [FILL_W-1:0]          r_fill_val;
  logic [PIX_BITS-1:0]        r_fill_pix;
  logic                       r_err;
  logic                       r_busy;
  logic                       r_fb_we;
  logic [X_BITS+Y_BITS-1:0]   r_fb_addr;
  logic [PIX_BITS-1:0]        r_fb_data;
  logic [7:0]                 r_rd_data;

  logic [7:0]        w_off_full;
  logic [2:0]        w_off;
  logic              w_in_win;
  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_wr_pix;
  logic              w_idle;
  logic              w_in_range;
  logic              w_pix_ok;
  logic              w_err_set;
  logic              w_err_clr;
  logic              w_fill_start;
  logic [FILL_W-1:0] w_fill_val;
  logic [X_BITS-1:0] w_xreg;
  logic [Y_BITS-1:0] w_yreg;
  logic [X_BITS-1:0] w_fx;
  logic [Y_BITS-1:0] w_fy;
  logic              w_fill_wrap;
  logic              w_xy_wrap;
  logic [7:0]        w_rd_mux;

  // Window decode: the lower-bound test stops addresses that wrap past
  // 8'hFF from aliasing into a window placed near the top of the map.
  assign w_off_full = BUS_ADDR - BASE_ADDR;
  assign w_in_win   = (BUS_ADDR >= BASE_ADDR) && (w_off_full[7:3] == 5'd0);
  assign w_off      = w_off_full[2:0];
  assign w_wr       = BUS_WE && w_in_win;
  assign w_wr_ctrl  = w_wr && (w_off == OFF_CTRL);
  assign w_wr_pix   = w_wr && (w_off == OFF_PIXEL);

  assign w_idle       = (r_state == IDLE);
  assign w_in_range   = (w_xreg <= X_LAST) && (w_yreg <= Y_LAST);
  assign w_pix_ok     = w_wr_pix && w_idle && w_in_range;
  // A pixel write is an error if it is out of range or arrives mid-fill.
  assign w_err_set    = w_wr_pix && !(w_idle && w_in_range);
  assign w_err_clr    = w_wr_ctrl && BUS_DATA[CTRL_ERR_CLR];
  assign w_fill_start = w_wr_ctrl && BUS_DATA[CTRL_FILL_START] && w_idle;
  assign w_fill_val   = BUS_DATA[CTRL_FILL_LSB +: FILL_W];

  vga_xy_counter #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) u_xy (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .i_clr   (1'b0),
    .i_inc   (w_pix_ok && r_auto_inc),
    .i_load_x(w_wr && (w_off == OFF_XREG)),
    .i_x     (BUS_DATA[X_BITS-1:0]),
    .i_load_y(w_wr && (w_off == OFF_YREG)),
    .i_y     (BUS_DATA[Y_BITS-1:0]),
    .o_x     (w_xreg),
    .o_y     (w_yreg),
    .o_wrap  (w_xy_wrap)
  );

  vga_xy_counter #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) u_fill (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .i_clr   (w_fill_start),
    .i_inc   (r_state == FILL),
    .i_load_x(1'b0),
    .i_x     ('0),
    .i_load_y(1'b0),
    .i_y     ('0),
    .o_x     (w_fx),
    .o_y     (w_fy),
    .o_wrap  (w_fill_wrap)
  );

  always_comb begin
    w_rd_mux = 8'h00;
    if (w_in_win) begin
      case (w_off)
        OFF_COL_FG: w_rd_mux = r_col_fg;
        OFF_COL_BG: w_rd_mux = r_col_bg;
        OFF_XREG:   w_rd_mux = 8'(w_xreg);
        OFF_YREG:   w_rd_mux = 8'(w_yreg);
        OFF_CTRL:   w_rd_mux = {4'(r_fill_val), 3'b000, r_auto_inc};
        OFF_STATUS: w_rd_mux = {6'd0, r_err, r_busy};
        OFF_RSVD:   w_rd_mux = 8'h00;
        default:    w_rd_mux = 8'h00;  // PIXEL is write-only
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state    <= IDLE;
      r_col_fg   <= '0;
      r_col_bg   <= '0;
      r_auto_inc <= 1'b0;
      r_fill_val <= '0;
      r_fill_pix <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_data  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_fb_we   <= 1'b0;
      r_rd_data <= w_rd_mux;

      if (w_wr && (w_off == OFF_COL_FG)) r_col_fg <= BUS_DATA;
      if (w_wr && (w_off == OFF_COL_BG)) r_col_bg <= BUS_DATA;
      if (w_wr_ctrl) begin
        r_auto_inc <= BUS_DATA[CTRL_AUTO_INC];
        r_fill_val <= w_fill_val;
      end

      if (w_err_clr)      r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_fill_start) begin
            r_state    <= FILL;
            r_busy     <= 1'b1;
            // Latched so later CTRL writes cannot change a running fill.
            r_fill_pix <= PIX_BITS'(w_fill_val);
          end else if (w_pix_ok) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= {w_yreg, w_xreg};
            r_fb_data <= BUS_DATA[PIX_BITS-1:0];
          end
        end
        FILL: begin
          r_fb_we   <= 1'b1;
          r_fb_addr <= {w_fy, w_fx};
          r_fb_data <= r_fill_pix;
          if (w_fill_wrap) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUS_RD_DATA = r_rd_data;
  assign CONFIG_COL  = {r_col_fg, r_col_bg};
  assign FB_ADDR     = r_fb_addr;
  assign FB_DATA     = r_fb_data;
  assign FB_WE       = r_fb_we;
  assign BUSY        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_fb_writer.sv
module tb_vga_fb_writer;

  localparam logic [7:0] BASE = 8'hB0;
  localparam int XB = 8;
  localparam int YB = 7;
  localparam int PB = 1;
  localparam int XM = 159;
  localparam int YM = 119;
  localparam int NPIX = (XM + 1) * (YM + 1);

  logic              CLK = 1'b0;
  logic              RESETN = 1'b0;
  logic [7:0]        BUS_ADDR = 8'h00;
  logic [7:0]        BUS_DATA = 8'h00;
  logic              BUS_WE = 1'b0;
  logic [7:0]        BUS_RD_DATA;
  logic [15:0]       CONFIG_COL;
  logic [XB+YB-1:0]  FB_ADDR;
  logic [PB-1:0]     FB_DATA;
  logic              FB_WE;
  logic              BUSY;
  logic              dbg_state;

  vga_fb_writer #(
    .BASE_ADDR(BASE), .X_BITS(XB), .Y_BITS(YB), .PIX_BITS(PB),
    .X_MAX(XM), .Y_MAX(YM)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
    .BUS_WE(BUS_WE), .BUS_RD_DATA(BUS_RD_DATA), .CONFIG_COL(CONFIG_COL),
    .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_WE(FB_WE), .BUSY(BUSY),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- frame buffer write monitor ----------------
  logic [15:0] obs_q[$];
  int          obs_cyc_q[$];
  logic [15:0] exp_q[$];
  always @(negedge CLK) begin
    if (RESETN && FB_WE) begin
      obs_q.push_back({FB_DATA, FB_ADDR});
      obs_cyc_q.push_back(cyc);
    end
  end

  // ---------------- reference model state ----------------
  int m_fg, m_bg, m_x, m_y, m_auto, m_fill, m_err;
  int n_chk = 0;
  int n_pass = 0;

  task automatic model_reset();
    m_fg = 0; m_bg = 0; m_x = 0; m_y = 0; m_auto = 0; m_fill = 0; m_err = 0;
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    int off;
    if (a < BASE || a > BASE + 8'd7) return 8'h00;
    off = int'(a) - int'(BASE);
    case (off)
      0: return 8'(m_fg);
      1: return 8'(m_bg);
      2: return 8'(m_x);
      3: return 8'(m_y);
      5: return 8'((m_fill << 4) | m_auto);
      6: return 8'(m_err << 1);
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle bus write plus the model's view of the register effect.
  task automatic wr_reg(input int off, input int d);
    BUS_ADDR = 8'(int'(BASE) + off);
    BUS_DATA = 8'(d);
    BUS_WE   = 1'b1;
    tick();
    BUS_WE   = 1'b0;
    case (off)
      0: m_fg = d & 255;
      1: m_bg = d & 255;
      2: m_x  = d & 255;
      3: m_y  = d & 127;
      5: begin
        m_auto = d & 1;
        m_fill = (d >> 4) & ((1 << PB) - 1);
        if ((d & 8) != 0) m_err = 0;
      end
      default: ;
    endcase
  endtask

  task automatic rd_chk(input string tag, input int off);
    BUS_ADDR = 8'(int'(BASE) + off);
    tick();
    chk(tag, BUS_RD_DATA, exp_rd(BUS_ADDR));
  endtask

  task automatic pix(input string tag, input int d);
    bit in_rng;
    int idx;
    in_rng = (m_x <= XM) && (m_y <= YM);
    wr_reg(4, d);
    if (in_rng) begin
      chk({tag, "_we"}, FB_WE, 1);
      chk({tag, "_addr"}, FB_ADDR, m_y * 256 + m_x);
      chk({tag, "_data"}, FB_DATA, d & ((1 << PB) - 1));
      if (m_auto != 0) begin
        idx = (m_y * (XM + 1) + m_x + 1) % NPIX;
        m_y = idx / (XM + 1);
        m_x = idx % (XM + 1);
      end
    end else begin
      chk({tag, "_nowe"}, FB_WE, 0);
      m_err = 1;
    end
    tick();
    chk({tag, "_single"}, FB_WE, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int busy_cnt, n_bad;
    logic [15:0] first_bad_obs, first_bad_exp;
    int fg, bg;

    model_reset();
    #2;
    chk("rst_fb_we", FB_WE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_col", CONFIG_COL, 0);
    chk("rst_rd", BUS_RD_DATA, 0);
    chk("rst_addr", FB_ADDR, 0);
    repeat (3) @(posedge CLK);
    #1 RESETN = 1'b1;
    tick();

    // colours and readback
    wr_reg(0, 8'h5A);
    wr_reg(1, 8'hA5);
    chk("col_cfg", CONFIG_COL, 16'h5AA5);
    rd_chk("rd_fg", 0);
    chk("rd_fg_const", BUS_RD_DATA, 8'h5A);
    rd_chk("rd_bg", 1);
    wr_reg(7, 8'hFF);
    rd_chk("rd_rsvd", 7);
    BUS_ADDR = 8'h10;
    tick();
    chk("rd_outside", BUS_RD_DATA, 0);
    BUS_ADDR = 8'hB8;
    tick();
    chk("rd_above", BUS_RD_DATA, 0);
    for (int i = 0; i < 4; i++) begin
      fg = $urandom_range(0, 255);
      bg = $urandom_range(0, 255);
      wr_reg(0, fg);
      wr_reg(1, bg);
      chk("col_rand", CONFIG_COL, (fg << 8) | bg);
      rd_chk("rd_fg_rand", 0);
    end

    // directed pixel write
    wr_reg(2, 10);
    wr_reg(3, 20);
    rd_chk("rd_x", 2);
    rd_chk("rd_y", 3);
    pix("pix_dir", 1);
    chk("pix_dir_addr_const", m_y * 256 + m_x, 16'h140A);

    // random pixels, auto-increment off, some out of range
    for (int i = 0; i < 12; i++) begin
      wr_reg(2, $urandom_range(0, 170));
      wr_reg(3, $urandom_range(0, 127));
      pix("pix_rand", $urandom_range(0, 255));
      rd_chk("status_rand", 6);
    end
    wr_reg(5, 8'h08);
    rd_chk("status_clr", 6);

    // auto-increment wrap at the last pixel
    wr_reg(5, 8'h01);
    rd_chk("rd_ctrl_auto", 5);
    wr_reg(2, XM);
    wr_reg(3, YM);
    pix("wrap0", 1);
    pix("wrap1", 0);
    pix("wrap2", 1);
    rd_chk("wrap_x", 2);
    rd_chk("wrap_y", 3);
    rd_chk("wrap_status", 6);
    // auto-increment across a row edge from a random start
    wr_reg(2, $urandom_range(XM - 3, XM));
    wr_reg(3, $urandom_range(0, YM));
    for (int i = 0; i < 6; i++) pix("auto_rand", $urandom_range(0, 1));
    rd_chk("auto_x", 2);
    rd_chk("auto_y", 3);

    // range check and error clear
    wr_reg(5, 8'h00);
    wr_reg(2, 160);
    wr_reg(3, 5);
    pix("range_x", 1);
    rd_chk("range_status", 6);
    chk("range_status_const", BUS_RD_DATA, 8'h02);
    wr_reg(5, 8'h08);
    rd_chk("range_clr", 6);
    wr_reg(5, 8'hF1);
    rd_chk("rd_ctrl_trunc", 5);

    // full-screen fill with a pixel write and register writes mid-fill
    wr_reg(5, 8'h08);
    exp_q.delete();
    for (int i = 0; i < NPIX; i++)
      exp_q.push_back({1'b1, 7'(i / (XM + 1)), 8'(i % (XM + 1))});
    obs_q.delete();
    obs_cyc_q.delete();
    wr_reg(5, 8'h12);
    chk("fill_busy_start", BUSY, 1);
    chk("fill_dbg_state", dbg_state, 1);
    busy_cnt = 0;
    for (int i = 0; i < NPIX + 800 && BUSY; i++) begin
      busy_cnt++;
      if (i == 100) begin
        BUS_ADDR = BASE + 8'd4; BUS_DATA = 8'h01; BUS_WE = 1'b1;
        m_err = 1;
      end else if (i == 200) begin
        BUS_ADDR = BASE + 8'd2; BUS_DATA = 8'd33; BUS_WE = 1'b1;
        m_x = 33;
      end else if (i == 300) begin
        BUS_ADDR = BASE + 8'd5; BUS_DATA = 8'h02; BUS_WE = 1'b1;
        m_auto = 0; m_fill = 0;
      end else begin
        BUS_WE = 1'b0;
      end
      tick();
    end
    BUS_WE = 1'b0;
    repeat (3) tick();
    chk("fill_busy_cycles", busy_cnt, NPIX);
    chk("fill_we_count", obs_q.size(), NPIX);
    n_bad = 0;
    first_bad_obs = '0;
    first_bad_exp = '0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        if (n_bad == 0) begin
          first_bad_obs = obs_q[i];
          first_bad_exp = exp_q[i];
        end
        n_bad++;
      end
    end
    chk("fill_first_bad_write", first_bad_obs, first_bad_exp);
    chk("fill_bad_count", n_bad, 0);
    if (obs_cyc_q.size() > 0)
      chk("fill_contiguous", obs_cyc_q[$] - obs_cyc_q[0], NPIX - 1);
    chk("fill_busy_end", BUSY, 0);
    rd_chk("fill_status", 6);
    rd_chk("fill_xreg", 2);
    rd_chk("fill_ctrl", 5);

    // reset in the middle of a fill
    wr_reg(5, 8'h08);
    wr_reg(5, 8'h02);
    repeat (500) tick();
    chk("midfill_busy", BUSY, 1);
    #3 RESETN = 1'b0;
    #1;
    model_reset();
    chk("midrst_we", FB_WE, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_col", CONFIG_COL, 0);
    chk("midrst_addr", FB_ADDR, 0);
    chk("midrst_data", FB_DATA, 0);
    chk("midrst_rd", BUS_RD_DATA, 0);
    @(posedge CLK);
    #1 RESETN = 1'b1;
    obs_q.delete();
    repeat (50) tick();
    chk("postrst_no_we", obs_q.size(), 0);
    rd_chk("postrst_status", 6);
    rd_chk("postrst_x", 2);
    rd_chk("postrst_fg", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
